// File: rtl/slc3_run_ctrl_if.sv
// Board/CPU-facing signal bundle for the SLC-3 run controller.
// master = the board/CPU side, slave = the run controller.
interface slc3_run_ctrl_if #(
    parameter int N_BTN = 2,
    parameter int PC_W  = 16
);
    logic [N_BTN-1:0] btn_n;
    logic [1:0]       mode;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  bp_addr;
    logic             instr_done;
    logic             pause_req;
    logic [N_BTN-1:0] btn_pulse;
    logic             cpu_en;
    logic [1:0]       state;
    logic             bp_hit;

    modport master (
        output btn_n, mode, pc, bp_addr, instr_done, pause_req,
        input  btn_pulse, cpu_en, state, bp_hit
    );

    modport slave (
        input  btn_n, mode, pc, bp_addr, instr_done, pause_req,
        output btn_pulse, cpu_en, state, bp_hit
    );
endinterface

// File: rtl/slc3_run_ctrl.sv
// SLC-3 run controller: debounces the push buttons and gates the CPU clock
// enable through an IDLE/RUN/PAUSED machine with single-step and breakpoint halts.
module slc3_run_ctrl #(
    parameter int N_BTN     = 2,
    parameter int DB_CYCLES = 16,
    parameter int PC_W      = 16
) (
    input logic            clk,
    input logic            rst_n,
    slc3_run_ctrl_if.slave bus
);
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_PAUSED = 2'b10;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] db_level;
    logic [N_BTN-1:0] db_level_d;
    logic [N_BTN-1:0] btn_pulse_q;
    logic [CNT_W-1:0] db_cnt [N_BTN];

    logic [1:0]       state_q;
    logic             bp_hit_q;
    logic [PC_W-1:0]  pc_diff;
    logic             pc_match;
    logic             run_p;
    logic             cont_p;
    logic             step_hit;
    logic             brk_hit;
    logic             halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '1;
            sync2       <= '1;
            db_level_d  <= '1;
            btn_pulse_q <= '0;
        end else begin
            sync1       <= bus.btn_n;
            sync2       <= sync1;
            db_level_d  <= db_level;
            btn_pulse_q <= db_level_d & ~db_level;
        end
    end

    // The counter only runs while the synchronised level disagrees with the
    // debounced one, so any bounce back to the old level restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= '1;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pc_diff  = bus.pc ^ bus.bp_addr;
    assign pc_match = (pc_diff == '0);
    assign run_p    = btn_pulse_q[0];
    assign cont_p   = btn_pulse_q[1];
    assign step_hit = bus.instr_done && (bus.mode == 2'b01);
    assign brk_hit  = bus.instr_done && (bus.mode == 2'b10) && pc_match;
    assign halt     = bus.pause_req || step_hit || brk_hit;

    // Run always wins over Continue; bp_hit is only ever set by a breakpoint halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            bp_hit_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run_p) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (run_p) begin
                        state_q  <= ST_IDLE;
                        bp_hit_q <= 1'b0;
                    end else if (halt) begin
                        state_q <= ST_PAUSED;
                        if (brk_hit) begin
                            bp_hit_q <= 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (run_p) begin
                        state_q  <= ST_IDLE;
                        bp_hit_q <= 1'b0;
                    end else if (cont_p) begin
                        state_q  <= ST_RUN;
                        bp_hit_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    bp_hit_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.btn_pulse = btn_pulse_q;
    assign bus.state     = state_q;
    assign bus.cpu_en    = (state_q == ST_RUN);
    assign bus.bp_hit    = bp_hit_q;
endmodule

// File: tb/tb_slc3_run_ctrl.sv
// Testbench for slc3_run_ctrl: directed scenarios with literal expectations,
// then randomized stimulus checked every cycle against a history-based model.
module tb_slc3_run_ctrl;
    localparam int N_BTN     = 3;
    localparam int DB_CYCLES = 4;
    localparam int PC_W      = 16;

    localparam logic [1:0] M_IDLE   = 2'b00;
    localparam logic [1:0] M_RUN    = 2'b01;
    localparam logic [1:0] M_PAUSED = 2'b10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    slc3_run_ctrl_if #(.N_BTN(N_BTN), .PC_W(PC_W)) bus ();

    slc3_run_ctrl #(.N_BTN(N_BTN), .DB_CYCLES(DB_CYCLES), .PC_W(PC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;
    bit compare_on = 1'b0;
    int pulse_cnt [N_BTN] = '{default: 0};

    logic [N_BTN-1:0] cur_btn = '1;
    logic [1:0]       cur_mode = 2'b00;
    logic [PC_W-1:0]  cur_pc = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: raw samples per edge since reset; the synchronised value after
    // edge e is the raw value sampled at edge e-1 (all released before that).
    logic [N_BTN-1:0] raw_hist [$];
    int               m_edge;
    logic [N_BTN-1:0] m_db;
    logic [N_BTN-1:0] m_fell;
    logic [N_BTN-1:0] m_pulse;
    logic [1:0]       m_state;
    logic             m_bp;

    function automatic logic [N_BTN-1:0] synced_after(input int e);
        if (e < 2) return '1;
        return raw_hist[e-2];
    endfunction

    function automatic logic [N_BTN-1:0] settle(input int e, input logic [N_BTN-1:0] db);
        logic [N_BTN-1:0] res;
        logic [N_BTN-1:0] latest;
        logic [N_BTN-1:0] past;
        bit steady;
        res = db;
        latest = synced_after(e - 1);
        for (int i = 0; i < N_BTN; i++) begin
            steady = 1'b1;
            for (int k = 2; k <= DB_CYCLES; k++) begin
                past = synced_after(e - k);
                if (past[i] != latest[i]) steady = 1'b0;
            end
            if (steady) res[i] = latest[i];
        end
        return res;
    endfunction

    function automatic logic [2:0] fsm_model(input logic [1:0] st, input logic bp, input logic run,
                                             input logic cont, input logic [1:0] md, input logic done,
                                             input logic pause, input logic [PC_W-1:0] pc,
                                             input logic [PC_W-1:0] bpa);
        bit breakpoint;
        bit stop;
        breakpoint = done && (md == 2'b10) && (pc == bpa);
        stop = pause || (done && (md == 2'b01)) || breakpoint;
        if (run) return (st == M_IDLE) ? {1'b0, M_RUN} : {1'b0, M_IDLE};
        if (st == M_RUN && stop) return {bp | breakpoint, M_PAUSED};
        if (st == M_PAUSED && cont) return {1'b0, M_RUN};
        return {bp, st};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_hist.delete();
            m_edge  <= 0;
            m_db    <= '1;
            m_fell  <= '0;
            m_pulse <= '0;
            m_state <= M_IDLE;
            m_bp    <= 1'b0;
        end else begin
            {m_bp, m_state} <= fsm_model(m_state, m_bp, m_pulse[0], m_pulse[1], bus.mode,
                                         bus.instr_done, bus.pause_req, bus.pc, bus.bp_addr);
            m_db    <= settle(m_edge + 1, m_db);
            m_fell  <= m_db & ~settle(m_edge + 1, m_db);
            m_pulse <= m_fell;
            raw_hist.push_back(bus.btn_n);
            m_edge  <= m_edge + 1;
        end
    end

    always @(negedge clk) begin
        if (compare_on) begin
            checkOutput("btn_pulse", 32'(bus.btn_pulse), 32'(m_pulse));
            checkOutput("state", 32'(bus.state), 32'(m_state));
            checkOutput("cpu_en", 32'(bus.cpu_en), 32'(m_state == M_RUN));
            checkOutput("bp_hit", 32'(bus.bp_hit), 32'(m_bp));
        end
        for (int i = 0; i < N_BTN; i++) begin
            if (bus.btn_pulse[i]) pulse_cnt[i] <= pulse_cnt[i] + 1;
        end
    end

    task automatic applyStimulus(input logic [N_BTN-1:0] b, input logic [1:0] m, input logic [PC_W-1:0] p,
                                 input logic done, input logic pause);
        @(negedge clk);
        #1;
        bus.btn_n      = b;
        bus.mode       = m;
        bus.pc         = p;
        bus.instr_done = done;
        bus.pause_req  = pause;
        cur_btn  = b;
        cur_mode = m;
        cur_pc   = p;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(cur_btn, cur_mode, cur_pc, 1'b0, 1'b0);
    endtask

    task automatic press(input logic [N_BTN-1:0] which, input int hold);
        applyStimulus(~which, cur_mode, cur_pc, 1'b0, 1'b0);
        idle(hold - 1);
        applyStimulus('1, cur_mode, cur_pc, 1'b0, 1'b0);
        idle(10);
    endtask

    task automatic pulseDone(input logic [1:0] m, input logic [PC_W-1:0] p);
        applyStimulus(cur_btn, m, p, 1'b1, 1'b0);
        applyStimulus(cur_btn, m, p, 1'b0, 1'b0);
    endtask

    // Run press from IDLE: pulse must appear exactly after the 7th edge.
    task automatic runPressTimed(input string tag);
        applyStimulus(cur_btn & ~N_BTN'(1), cur_mode, cur_pc, 1'b0, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            if (c >= 6 && c <= 8)
                checkOutput($sformatf("%s run pulse edge %0d", tag, c), 32'(bus.btn_pulse[0]), 32'(c == 7));
            if (c == 8) begin
                checkOutput({tag, " state after run"}, 32'(bus.state), 32'(M_RUN));
                checkOutput({tag, " cpu_en after run"}, 32'(bus.cpu_en), 32'd1);
            end
        end
        idle(11);
        applyStimulus('1, cur_mode, cur_pc, 1'b0, 1'b0);
        idle(10);
    endtask

    int base;
    int hold [N_BTN] = '{default: 0};
    logic [N_BTN-1:0] rb = '1;
    logic [1:0] md = 2'b00;
    logic [PC_W-1:0] p;

    initial begin
        bus.btn_n = '1;
        bus.mode = 2'b00;
        bus.pc = '0;
        bus.bp_addr = '0;
        bus.instr_done = 1'b0;
        bus.pause_req = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset state", 32'(bus.state), 32'(M_IDLE));
        checkOutput("reset cpu_en", 32'(bus.cpu_en), 32'd0);
        checkOutput("reset bp_hit", 32'(bus.bp_hit), 32'd0);
        checkOutput("reset btn_pulse", 32'(bus.btn_pulse), 32'd0);
        #1 rst_n = 1'b1;
        compare_on = 1'b1;
        idle(3);

        runPressTimed("clean");

        base = pulse_cnt[1];
        repeat (3) begin
            applyStimulus(3'b101, cur_mode, cur_pc, 1'b0, 1'b0);
            idle(2);
            applyStimulus('1, cur_mode, cur_pc, 1'b0, 1'b0);
            idle(2);
        end
        idle(10);
        checkOutput("bounce pulses", 32'(pulse_cnt[1] - base), 32'd0);
        checkOutput("bounce state", 32'(bus.state), 32'(M_RUN));

        pulseDone(2'b01, 16'h3000);
        checkOutput("step paused", 32'(bus.state), 32'(M_PAUSED));
        checkOutput("step cpu_en", 32'(bus.cpu_en), 32'd0);
        checkOutput("step bp_hit", 32'(bus.bp_hit), 32'd0);
        press(3'b010, 10);
        checkOutput("step continue", 32'(bus.state), 32'(M_RUN));
        pulseDone(2'b01, 16'h3001);
        checkOutput("step paused again", 32'(bus.state), 32'(M_PAUSED));
        press(3'b010, 10);

        bus.bp_addr = 16'h3005;
        pulseDone(2'b10, 16'h3004);
        checkOutput("bp miss state", 32'(bus.state), 32'(M_RUN));
        pulseDone(2'b10, 16'h3005);
        checkOutput("bp hit state", 32'(bus.state), 32'(M_PAUSED));
        checkOutput("bp hit flag", 32'(bus.bp_hit), 32'd1);
        press(3'b010, 10);
        checkOutput("bp continue state", 32'(bus.state), 32'(M_RUN));
        checkOutput("bp continue flag", 32'(bus.bp_hit), 32'd0);

        pulseDone(2'b10, 16'h3005);
        checkOutput("bp hit again", 32'(bus.bp_hit), 32'd1);
        press(3'b011, 10);
        checkOutput("priority state", 32'(bus.state), 32'(M_IDLE));
        checkOutput("priority flag", 32'(bus.bp_hit), 32'd0);

        base = pulse_cnt[2];
        press(3'b100, 10);
        checkOutput("gp button pulses", 32'(pulse_cnt[2] - base), 32'd1);
        checkOutput("gp button state", 32'(bus.state), 32'(M_IDLE));

        applyStimulus('1, 2'b00, 16'h0000, 1'b0, 1'b0);
        runPressTimed("pre-reset");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset state", 32'(bus.state), 32'(M_IDLE));
        checkOutput("async reset cpu_en", 32'(bus.cpu_en), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        runPressTimed("post-reset");

        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (hold[i] == 0) begin
                    rb[i] = (i == 0) ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 10);
                end else begin
                    hold[i]--;
                end
            end
            if ($urandom_range(0, 63) == 0) md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 127) == 0) bus.bp_addr = 16'($urandom);
            case ($urandom_range(0, 3))
                0: p = bus.bp_addr;
                1: p = bus.bp_addr ^ 16'h8000;
                2: p = bus.bp_addr ^ 16'h0001;
                default: p = 16'($urandom);
            endcase
            applyStimulus(rb, md, p, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
            if (cyc == 1500) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        applyStimulus('1, 2'b00, 16'h0000, 1'b0, 1'b0);
        idle(12);
        compare_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/slc3_run_ctrl.md
SLC3_RUN_CTRL -- requirements
Module: slc3_run_ctrl

Interface
REQ-001 Parameter N_BTN, default 2: number of push-button channels; N_BTN SHALL be at least 2.
REQ-002 Parameter DB_CYCLES, default 16: debounce stability window in clock cycles; DB_CYCLES SHALL be at least 1.
REQ-003 Parameter PC_W, default 16: program-counter width.
REQ-004 Clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 btn_n  in  N_BTN  raw active-low push buttons: bit0 = Run, bit1 = Continue, higher bits general-purpose.
REQ-007 mode  in  2  execution mode: 00 free-run, 01 single-step, 10 breakpoint, 11 treated as free-run.
REQ-008 pc  in  PC_W  current CPU program counter.
REQ-009 bp_addr  in  PC_W  breakpoint address, typically driven from SW.
REQ-010 instr_done  in  1  one-cycle pulse from the CPU when an instruction retires.
REQ-011 pause_req  in  1  one-cycle pulse from the CPU when it executes a PAUSE instruction.
REQ-012 btn_pulse  out  N_BTN  one-cycle pulse per debounced press, one bit per button.
REQ-013 cpu_en  out  1  CPU clock-enable.
REQ-014 state  out  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSED.
REQ-015 bp_hit  out  1  sticky flag: the CPU stopped on a breakpoint.

Function
REQ-016 Synchroniser: each btn_n bit SHALL pass through its own 2-flop synchroniser.
REQ-017 Debounce counter: each channel SHALL have a counter that clears on any change of the synchronised level.
REQ-018 Debounced level update: the debounced level SHALL take the synchronised value only after that value has been stable for DB_CYCLES consecutive cycles.
REQ-019 Press pulse: btn_pulse[i] SHALL assert for exactly one cycle when debounced level i goes 1 to 0; a release SHALL generate no pulse.
REQ-020 Press latency: from a clean raw falling edge to the btn_pulse assertion SHALL be 2+DB_CYCLES+1 cycles.
REQ-021 Bounce rejection: a raw glitch shorter than DB_CYCLES cycles SHALL produce no pulse.
REQ-022 IDLE: cpu_en=0; a Run pulse SHALL move the FSM to RUN.
REQ-023 RUN: cpu_en=1.
REQ-024 RUN to PAUSED: the FSM SHALL move to PAUSED on any of the following:
- pause_req=1;
- mode=01 and instr_done=1;
- mode=10 and instr_done=1 and pc==bp_addr.
REQ-025 bp_hit set: the breakpoint condition of REQ-024 SHALL also set bp_hit; pause_req or single-step alone SHALL NOT set bp_hit.
REQ-026 pause_req with breakpoint: if pause_req and the breakpoint condition are both true in the same cycle, the FSM SHALL go to PAUSED and bp_hit SHALL be set.
REQ-027 PAUSED: cpu_en=0; a Continue pulse SHALL move the FSM to RUN and clear bp_hit in the same edge.
REQ-028 Run abort: a Run pulse in RUN or PAUSED SHALL return the FSM to IDLE and clear bp_hit.
REQ-029 Simultaneous Run and Continue pulses: Run SHALL take priority.
REQ-030 A Continue pulse in IDLE or RUN SHALL be ignored.
REQ-031 Output timing: cpu_en and state SHALL be decoded from the registered state; cpu_en SHALL drop in the cycle after the event that causes RUN to PAUSED.
REQ-032 Mode sampling: mode SHALL be sampled only at instr_done; a mode change has no other effect.
REQ-033 btn_pulse bits 2 and above SHALL only produce pulses and SHALL NOT affect the FSM.
REQ-034 PC compare: the compare SHALL be a full PC_W-bit equality; no wrap or masking SHALL be applied.

Reset
REQ-035 While Reset=0: state=IDLE, cpu_en=0, bp_hit=0, btn_pulse=0, debounce counters=0, synchronisers and debounced levels=1 (released).
REQ-036 Reset assertion mid-operation SHALL force all REQ-035 values immediately, without waiting for a clock edge.
REQ-037 After Reset is released, the first Run press SHALL require a full debounce window.

Verification (DB_CYCLES=4, PC_W=16)
REQ-038 Clean Run press: btn_n[0] held low 20 cycles -> exactly one btn_pulse[0] at cycle 7; state 00->01; cpu_en=1 the next cycle.
REQ-039 Bounce: btn_n[1] pulsed low for 3 cycles, three times -> no btn_pulse[1]; state unchanged.
REQ-040 Single-step: mode=01, RUN, instr_done pulse -> state=10, cpu_en=0; Continue press -> RUN; next instr_done -> PAUSED again.
REQ-041 Breakpoint: mode=10, bp_addr=0x3005:
- pc=0x3004 with instr_done -> stays RUN;
- pc=0x3005 with instr_done -> PAUSED, bp_hit=1;
- Continue press -> RUN, bp_hit=0.
REQ-042 Priority: Run and Continue pulses in the same cycle while PAUSED -> IDLE, bp_hit=0.
REQ-043 Reset mid-run: Reset=0 asserted between clock edges while RUN -> cpu_en=0 and state=00 before the next edge; after release, a Run press takes 7 cycles to pulse.
